// File: rtl/rf_arb_pkg.sv
// Shared constants and state encoding for the register-file write-port arbiter.
package rf_arb_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int NREG_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; ptr names the requester favoured on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // Every grant is a transfer, so hand the tie to the other side next time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ptr <= 1'b0;
    else if (|grant) ptr <= ~grant[1];
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Owns the register file write port: zero-clear sweep after reset, then
// round-robin sharing between EX and load writeback, dropping writes to R0.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW             = DW_DEF,
  parameter int AW             = AW_DEF,
  parameter int NREG           = NREG_DEF,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] PW,
  output logic          LE,
  output logic          busy
);

  localparam state_e ST_INIT = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_e        state;
  logic [AW-1:0] clr_cnt;
  logic [1:0]    grant;
  logic          run_en;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_data;

  assign busy   = (state == ST_CLEAR);
  // Gating with Rst_n keeps ready low while reset is held, even in RUN-at-reset builds.
  assign run_en = (state == ST_RUN) && Rst_n;

  rr_arbiter2 u_arb (
    .clk   (Clk),
    .rst_n (Rst_n),
    .en    (run_en),
    .valid ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign w_addr     = grant[1] ? req1_addr : req0_addr;
  assign w_data     = grant[1] ? req1_data : req0_data;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
      LE      <= 1'b0;
      RW      <= '0;
      PW      <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          LE      <= 1'b1;
          RW      <= clr_cnt;
          PW      <= '0;
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(NREG - 1)) state <= ST_RUN;
        end
        default: begin
          // R0 writes are still accepted and latched, just never enabled.
          if (|grant) begin
            RW <= w_addr;
            PW <= w_data;
            LE <= (w_addr != AW'(REG_ZERO));
          end else begin
            LE <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a cycle-level
// reference model and a behavioural register file.
module tb_rf_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic        r0, r1, LE, busy;
  logic [4:0]  RW;
  logic [31:0] PW;

  logic        nc_v0 = 1'b0, nc_v1 = 1'b0;
  logic [4:0]  nc_a0 = '0, nc_a1 = '0;
  logic [31:0] nc_d0 = '0, nc_d1 = '0;
  logic        nc_r0, nc_r1, nc_le, nc_busy;
  logic [4:0]  nc_rw;
  logic [31:0] nc_pw;

  always #5 Clk = ~Clk;

  rf_write_arbiter dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(v0), .req0_ready(r0), .req0_addr(a0), .req0_data(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_addr(a1), .req1_data(d1),
    .RW(RW), .PW(PW), .LE(LE), .busy(busy)
  );

  rf_write_arbiter #(.CLEAR_ON_RESET(1'b0)) dut_nc (
    .Clk(Clk), .Rst_n(Rst_n),
    .req0_valid(nc_v0), .req0_ready(nc_r0), .req0_addr(nc_a0), .req0_data(nc_d0),
    .req1_valid(nc_v1), .req1_ready(nc_r1), .req1_addr(nc_a1), .req1_data(nc_d1),
    .RW(nc_rw), .PW(nc_pw), .LE(nc_le), .busy(nc_busy)
  );

  // Behavioural register file fed by the DUT write port
  logic [31:0] rf [32];
  always @(posedge Clk) if (LE) rf[RW] <= PW;

  int passed = 0;
  int total  = 0;

  // Reference model state
  int          m_clr;
  bit          m_ptr;
  logic        m_le;
  logic [4:0]  m_rw;
  logic [31:0] m_pw;
  logic [31:0] m_rf [32];
  bit          acc0, acc1;
  int          nc_stage = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_clr = 32; m_ptr = 1'b0; m_le = 1'b0; m_rw = '0; m_pw = '0;
  endtask

  // One clock cycle: check at negedge, advance model, drive after posedge.
  task automatic tick();
    logic g0, g1;
    logic [4:0] wa;
    logic [31:0] wd;
    @(negedge Clk);
    g0 = 1'b0; g1 = 1'b0;
    if (m_clr == 0) begin
      g0 = v0 && (!v1 || !m_ptr);
      g1 = v1 && !g0;
    end
    chk("busy", 32'(busy), 32'(m_clr > 0));
    chk("req0_ready", 32'(r0), 32'(g0));
    chk("req1_ready", 32'(r1), 32'(g1));
    chk("LE", 32'(LE), 32'(m_le));
    if (m_le) begin
      chk("RW", 32'(RW), 32'(m_rw));
      chk("PW", PW, m_pw);
    end
    case (nc_stage)
      0: begin
        chk("nc_busy", 32'(nc_busy), 32'd0);
        chk("nc_ready0", 32'(nc_r0), 32'd1);
      end
      1: begin
        chk("nc_LE", 32'(nc_le), 32'd1);
        chk("nc_RW", 32'(nc_rw), 32'd4);
        chk("nc_PW", nc_pw, 32'h44);
      end
      2: chk("nc_LE_off", 32'(nc_le), 32'd0);
      default: ;
    endcase
    acc0 = g0; acc1 = g1;
    if (m_clr > 0) begin
      m_le = 1'b1; m_rw = 5'(32 - m_clr); m_pw = '0;
      m_rf[32 - m_clr] = '0;
      m_clr--;
    end else if (g0 || g1) begin
      wa = g1 ? a1 : a0;
      wd = g1 ? d1 : d0;
      m_le = (wa != 0); m_rw = wa; m_pw = wd;
      if (wa != 0) m_rf[wa] = wd;
      m_ptr = g0;
    end else begin
      m_le = 1'b0;
    end
    @(posedge Clk); #1;
    if (nc_stage == 0) nc_v0 = 1'b0;
    if (nc_stage < 3) nc_stage++;
  endtask

  initial begin
    nc_v0 = 1'b1; nc_a0 = 5'd4; nc_d0 = 32'h44;
    v0 = 1'b1; a0 = 5'd2; d0 = 32'h22;
    model_reset();
    @(posedge Clk); #1;
    chk("rst_LE", 32'(LE), 32'd0);
    chk("rst_RW", 32'(RW), 32'd0);
    chk("rst_PW", PW, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready0", 32'(r0), 32'd0);
    chk("rst_nc_ready0", 32'(nc_r0), 32'd0);
    chk("rst_nc_busy", 32'(nc_busy), 32'd0);
    v0 = 1'b0;
    Rst_n = 1'b1;

    // Abort the sweep part way with an asynchronous reset
    for (int i = 0; i < 5; i++) tick();
    #1 Rst_n = 1'b0;
    #1;
    chk("async_clr_LE", 32'(LE), 32'd0);
    chk("async_clr_RW", 32'(RW), 32'd0);
    chk("async_clr_busy", 32'(busy), 32'd1);
    #1 Rst_n = 1'b1;
    model_reset();

    // Full sweep, with a request waiting that must not be granted early
    v1 = 1'b1; a1 = 5'd12; d1 = 32'hC0FFEE;
    for (int i = 0; i < 34; i++) begin
      tick();
      if (acc1) v1 = 1'b0;
    end
    chk("sweep_done", 32'(m_clr), 32'd0);

    // Single requester
    v0 = 1'b1; a0 = 5'd5; d0 = 32'h14;
    tick();
    v0 = 1'b0;
    tick(); tick();
    chk("rf5", rf[5], 32'h14);

    // Contention for four cycles
    v0 = 1'b1; a0 = 5'd3; d0 = 32'hAAAA;
    v1 = 1'b1; a1 = 5'd7; d1 = 32'h5555;
    for (int i = 0; i < 4; i++) tick();
    v0 = 1'b0; v1 = 1'b0;
    tick(); tick();

    // R0 write is accepted but never reaches the file
    v1 = 1'b1; a1 = 5'd0; d1 = 32'hFFFF_FFFF;
    tick();
    v1 = 1'b0;
    tick(); tick();
    chk("rf0_raw", rf[0], 32'd0);
    chk("ptr_after_r0", 32'(m_ptr), 32'd0);

    // Same address from both sides: later write wins
    v0 = 1'b1; a0 = 5'd9; d0 = 32'h1;
    v1 = 1'b1; a1 = 5'd9; d1 = 32'h2;
    tick();
    if (acc0) v0 = 1'b0;
    if (acc1) v1 = 1'b0;
    tick();
    v0 = 1'b0; v1 = 1'b0;
    tick(); tick();
    chk("rf9", rf[9], 32'h2);

    // Randomized traffic obeying the hold-until-accepted protocol
    for (int i = 0; i < 400; i++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0); a0 = 5'($urandom_range(0, 31)); d0 = $urandom;
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 3) != 0); a1 = 5'($urandom_range(0, 31)); d1 = $urandom;
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    tick(); tick();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_rand[%0d]", r), rf[r], m_rf[r]);

    // Asynchronous reset while a write is on the port
    v0 = 1'b1; a0 = 5'd6; d0 = 32'h66;
    tick();
    chk("pre_rst_LE", 32'(LE), 32'd1);
    #1 Rst_n = 1'b0;
    #1;
    chk("async_run_LE", 32'(LE), 32'd0);
    chk("async_run_busy", 32'(busy), 32'd1);
    chk("async_run_ready0", 32'(r0), 32'd0);
    #1 Rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 36; i++) begin
      tick();
      if (acc0) v0 = 1'b0;
    end
    tick();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_end[%0d]", r), rf[r], m_rf[r]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
